rst_seq: RTL and testbench

Parametrised reset synchroniser and release sequencer. It takes the board-level asynchronous reset plus an optional synchronous software reset request and drives NUM_RST registered, active-high reset outputs. All outputs assert immediately; after a minimum stretch, they deassert one at a time in index order with a programmable spacing. It sits at the top of each clock domain, between the reset pin/PLL-lock logic and the domain's subsystems (e.g. memory controller first, then datapath, then host interface).

---
 rtl/rst_seq_if.sv | 18 +
 rtl/rst_seq.sv | 132 +++++++++++++
 tb/tb_rst_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rst_seq_if.sv
// Reset sequencer control/status bundle. The rst_ack vector exists only
// when RST_SEQ_ACK_EN is defined.
interface rst_seq_if #(
  parameter int unsigned NUM_RST = 3
);
  logic               sw_rst_req;
  logic [NUM_RST-1:0] rst_out;
  logic               rst_done;
`ifdef RST_SEQ_ACK_EN
  logic [NUM_RST-1:0] rst_ack;

  modport master (output sw_rst_req, rst_ack, input rst_out, rst_done);
  modport slave  (input sw_rst_req, rst_ack, output rst_out, rst_done);
`else
  modport master (output sw_rst_req, input rst_out, rst_done);
  modport slave  (input sw_rst_req, output rst_out, rst_done);
`endif
endinterface

// File: rtl/rst_seq.sv
// Reset synchroniser and ordered release sequencer for one clock domain.
// Define RST_SEQ_ACK_EN to gate each release on the previous channel's rst_ack.
module rst_seq #(
  parameter int unsigned SYNC_STAGES    = 4,
  parameter int unsigned NUM_RST        = 3,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STEP_CYCLES    = 8,
  parameter int unsigned CNT_W          = 8
) (
  input  logic     clk,
  input  logic     a_reset,
  rst_seq_if.slave rs
);

  localparam int unsigned IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_RST - 1);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_RST-1:0]     rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   step_ok;
  logic                   last_ready;

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_s = sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_ACK_EN
  // Channel idx waits on the ack of channel idx-1; the counter parks at STEP_LAST.
  assign step_ok    = rs.rst_ack[idx_q - 1'b1];
  assign last_ready = rs.rst_ack[NUM_RST-1];
`else
  assign step_ok    = 1'b1;
  assign last_ready = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    unique case (state_q)
      S_ASSERT: begin
        rst_d  = '1;
        done_d = 1'b0;
        if (rst_s) begin
          cnt_d = '0;
        end else if (cnt_q == STRETCH_LAST) begin
          cnt_d    = '0;
          rst_d[0] = 1'b0;
          if (NUM_RST == 1) begin
            state_d = S_RUN;
            done_d  = last_ready;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (cnt_q == STEP_LAST) begin
          if (step_ok) begin
            cnt_d        = '0;
            rst_d[idx_q] = 1'b0;
            if (idx_q == LAST_IDX) begin
              state_d = S_RUN;
              done_d  = last_ready;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        rst_d = '0;
        if (last_ready) done_d = 1'b1;
      end
      default: begin
        state_d = S_ASSERT;
        rst_d   = '1;
        done_d  = 1'b0;
      end
    endcase
    if (rs.sw_rst_req) begin
      state_d = S_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  assign rs.rst_out  = rst_q;
  assign rs.rst_done = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with default parameters; edge numbers count
// from the first clk edge after a_reset (or the last a_reset pulse) falls.
module tb_rst_seq;

  logic clk = 1'b0;
  logic a_reset;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned edge_n  = 0;
  int unsigned order_bad = 0;

  rst_seq_if #(.NUM_RST(3)) rs ();

  rst_seq #(
    .SYNC_STAGES(4), .NUM_RST(3), .STRETCH_CYCLES(16), .STEP_CYCLES(8), .CNT_W(8)
  ) dut (
    .clk    (clk),
    .a_reset(a_reset),
    .rs     (rs.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_n;
    logic        sw;
    logic [2:0]  rst;
    logic        done;
  } vec_t;

  // Releases must always be thermometer-ordered, and done implies all released.
  always @(negedge clk) begin
    if (!(rs.rst_out inside {3'b111, 3'b110, 3'b100, 3'b000}) ||
        (rs.rst_done && rs.rst_out != 3'b000))
      order_bad++;
  end

  task automatic check(input string name, input logic [2:0] exp_rst, input logic exp_done);
    n_tests++;
    if (rs.rst_out !== exp_rst || rs.rst_done !== exp_done) begin
      n_fail++;
      $display("FAIL %s edge %0d: rst_out=%b rst_done=%b, expected rst_out=%b rst_done=%b",
               name, edge_n, rs.rst_out, rs.rst_done, exp_rst, exp_done);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    while (edge_n + 1 < v.edge_n) begin
      @(posedge clk);
      edge_n++;
    end
    rs.sw_rst_req = v.sw;
    @(posedge clk);
    edge_n++;
    #1;
    rs.sw_rst_req = 1'b0;
    check(name, v.rst, v.done);
  endtask

  task automatic power_on();
    a_reset       = 1'b1;
    rs.sw_rst_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_hold", 3'b111, 1'b0);
    @(negedge clk);
    a_reset = 1'b0;
    edge_n  = 0;
  endtask

  vec_t vecs[15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1,  1'b0, 3'b111, 1'b0};
    vecs[1]  = '{4,  1'b0, 3'b111, 1'b0};
    vecs[2]  = '{19, 1'b0, 3'b111, 1'b0};
    vecs[3]  = '{20, 1'b0, 3'b110, 1'b0};
    vecs[4]  = '{27, 1'b0, 3'b110, 1'b0};
    vecs[5]  = '{28, 1'b0, 3'b100, 1'b0};
    vecs[6]  = '{35, 1'b0, 3'b100, 1'b0};
    vecs[7]  = '{36, 1'b0, 3'b000, 1'b1};
    vecs[8]  = '{49, 1'b0, 3'b000, 1'b1};
    vecs[9]  = '{50, 1'b1, 3'b111, 1'b0};
    vecs[10] = '{65, 1'b0, 3'b111, 1'b0};
    vecs[11] = '{66, 1'b0, 3'b110, 1'b0};
    vecs[12] = '{74, 1'b0, 3'b100, 1'b0};
    vecs[13] = '{81, 1'b0, 3'b100, 1'b0};
    vecs[14] = '{82, 1'b0, 3'b000, 1'b1};

`ifdef RST_SEQ_ACK_EN
    rs.rst_ack = 3'b111;
`endif

    // Power-on release followed by a software reset in RUN.
    power_on();
    foreach (vecs[i]) run_vec("poweron_sw50", vecs[i]);

    // Software reset while mid-release.
    power_on();
    run_vec("sw30_pre",  '{29, 1'b0, 3'b100, 1'b0});
    run_vec("sw30_hit",  '{30, 1'b1, 3'b111, 1'b0});
    run_vec("sw30_hold", '{45, 1'b0, 3'b111, 1'b0});
    run_vec("sw30_ch0",  '{46, 1'b0, 3'b110, 1'b0});
    run_vec("sw30_ch1",  '{54, 1'b0, 3'b100, 1'b0});
    run_vec("sw30_done", '{62, 1'b0, 3'b000, 1'b1});

    // Sub-cycle a_reset glitch during RELEASE.
    power_on();
    run_vec("glitch_pre", '{24, 1'b0, 3'b110, 1'b0});
    #1 a_reset = 1'b1;
    #1 check("glitch_async", 3'b111, 1'b0);
    #1 a_reset = 1'b0;
    edge_n = 0;
    run_vec("glitch_19", '{19, 1'b0, 3'b111, 1'b0});
    run_vec("glitch_20", '{20, 1'b0, 3'b110, 1'b0});
    run_vec("glitch_28", '{28, 1'b0, 3'b100, 1'b0});
    run_vec("glitch_36", '{36, 1'b0, 3'b000, 1'b1});

    // a_reset and sw_rst_req together; timing follows a_reset alone.
    a_reset       = 1'b1;
    rs.sw_rst_req = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("both_hold", 3'b111, 1'b0);
    @(negedge clk);
    a_reset       = 1'b0;
    rs.sw_rst_req = 1'b0;
    edge_n        = 0;
    run_vec("both_19", '{19, 1'b0, 3'b111, 1'b0});
    run_vec("both_20", '{20, 1'b0, 3'b110, 1'b0});
    run_vec("both_36", '{36, 1'b0, 3'b000, 1'b1});

`ifdef RST_SEQ_ACK_EN
    // Channel 1 release waits for rst_ack[0].
    rs.rst_ack = 3'b110;
    power_on();
    run_vec("ack_20", '{20, 1'b0, 3'b110, 1'b0});
    run_vec("ack_28", '{28, 1'b0, 3'b110, 1'b0});
    run_vec("ack_39", '{39, 1'b0, 3'b110, 1'b0});
    rs.rst_ack = 3'b111;
    run_vec("ack_40", '{40, 1'b0, 3'b100, 1'b0});
    run_vec("ack_47", '{47, 1'b0, 3'b100, 1'b0});
    run_vec("ack_48", '{48, 1'b0, 3'b000, 1'b1});
`endif

    n_tests++;
    if (order_bad != 0) begin
      n_fail++;
      $display("FAIL release_order: %0d illegal output samples, expected 0", order_bad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
